riscv_sdiv_32_32: RTL and testbench

Iterative 33-bit signed divider for the RISC-V M-extension execution unit; the counterpart of the core's 32x32 signed multiplier, sharing its request/ready handshake and its 33-bit operand convention. Computes quotient and remainder of `ai / bi` with a radix-2 restoring algorithm on operand magnitudes, then corrects the signs. Serves DIV, DIVU, REM and REMU. The caller sign-extends operands for signed ops and zero-extends them for unsigned ops, and selects the 32-bit quotient or remainder.

---
 rtl/riscv_sdiv_32_32_if.sv | 14 +
 rtl/riscv_sdiv_32_32.sv | 95 +++++++++
 tb/tb_riscv_sdiv_32_32.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_sdiv_32_32_if.sv
// Request/response bundle for the 33-bit iterative divider.
// The requester drives the operands; the divider returns busy/ready and the results.
interface riscv_sdiv_32_32_if;
  logic               req_i;
  logic signed [32:0] ai;
  logic signed [32:0] bi;
  logic               busy_o;
  logic               rdy_o;
  logic        [31:0] quot_o;
  logic        [31:0] rem_o;

  modport master (output req_i, ai, bi, input busy_o, rdy_o, quot_o, rem_o);
  modport slave  (input req_i, ai, bi, output busy_o, rdy_o, quot_o, rem_o);
endinterface

// File: rtl/riscv_sdiv_32_32.sv
// Radix-2 restoring divider on operand magnitudes with a final sign-correction step.
// Serves DIV/DIVU/REM/REMU; zero divisor and |ai|<|bi| skip the iteration loop.
module riscv_sdiv_32_32 (
  input  logic              clk_i,
  input  logic              rst_i,
  riscv_sdiv_32_32_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_SIGN_CORRECT} state_t;

  state_t      state;
  logic        sa, sb, dz, eo;
  logic [31:0] dvd, bmag;
  logic [32:0] prem;
  logic [5:0]  cnt;
  logic        rdy;
  logic [31:0] quot, rem;

  // Two's-complement negate done in 33 bits and truncated, so 0x8000_0000 maps to itself.
  function automatic logic [31:0] cneg(input logic [31:0] m, input logic n);
    logic [32:0] t;
    t = -{1'b0, m};
    return n ? t[31:0] : m;
  endfunction

  logic [31:0] a_mag, b_mag;
  logic [32:0] prem_sh;
  logic [33:0] trial;

  assign a_mag   = cneg(bus.ai[31:0], bus.ai[32]);
  assign b_mag   = cneg(bus.bi[31:0], bus.bi[32]);
  assign prem_sh = {prem[31:0], dvd[31]};
  assign trial   = {1'b0, prem_sh} - {2'b00, bmag};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      sa    <= 1'b0;
      sb    <= 1'b0;
      dz    <= 1'b0;
      eo    <= 1'b0;
      dvd   <= '0;
      bmag  <= '0;
      prem  <= '0;
      cnt   <= '0;
      rdy   <= 1'b0;
      quot  <= '0;
      rem   <= '0;
    end else begin
      rdy <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req_i) begin
            sa    <= bus.ai[32];
            sb    <= bus.bi[32];
            dvd   <= a_mag;
            bmag  <= b_mag;
            prem  <= '0;
            cnt   <= '0;
            dz    <= (b_mag == 32'd0);
            eo    <= (a_mag < b_mag);
            state <= ((b_mag == 32'd0) || (a_mag < b_mag)) ? S_SIGN_CORRECT : S_DIV;
          end
        end
        S_DIV: begin
          // A borrow out of the trial subtract means the divisor did not fit: restore.
          prem  <= trial[33] ? prem_sh : trial[32:0];
          dvd   <= {dvd[30:0], ~trial[33]};
          cnt   <= cnt + 6'd1;
          if (cnt == 6'd31) state <= S_SIGN_CORRECT;
        end
        S_SIGN_CORRECT: begin
          // On the short paths dvd still holds |ai|, so re-signing it yields ai[31:0].
          if (dz) begin
            quot <= 32'hFFFF_FFFF;
            rem  <= cneg(dvd, sa);
          end else if (eo) begin
            quot <= 32'd0;
            rem  <= cneg(dvd, sa);
          end else begin
            quot <= cneg(dvd, sa ^ sb);
            rem  <= cneg(prem[31:0], sa);
          end
          rdy   <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy_o = (state != S_IDLE);
  assign bus.rdy_o  = rdy;
  assign bus.quot_o = quot;
  assign bus.rem_o  = rem;
endmodule

// File: tb/tb_riscv_sdiv_32_32.sv
// Scoreboard bench for riscv_sdiv_32_32: directed RISC-V corner cases plus random
// signed/unsigned divisions checked against 64-bit integer arithmetic.
module tb_riscv_sdiv_32_32;
  logic clk_i = 1'b0;
  logic rst_i;

  riscv_sdiv_32_32_if bus ();
  riscv_sdiv_32_32 dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_rdy = 0;
  int   n_expect_rdy = 0;
  logic prev_rdy = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic (truncating division) plus the RISC-V
  // divide-by-zero rule; latency from the magnitude comparison.
  task automatic model(input logic [32:0] a, input logic [32:0] b,
                       output logic [31:0] q, output logic [31:0] r, output int lat);
    longint a64, b64, qq, rr, aa, bb;
    a64 = longint'($signed(a));
    b64 = longint'($signed(b));
    aa  = (a64 < 0) ? -a64 : a64;
    bb  = (b64 < 0) ? -b64 : b64;
    if (b64 == 0) begin
      q = 32'hFFFF_FFFF;
      r = a[31:0];
    end else begin
      qq = a64 / b64;
      rr = a64 % b64;
      q  = qq[31:0];
      r  = rr[31:0];
    end
    lat = (b64 == 0 || aa < bb) ? 1 : 33;
  endtask

  // Monitor: every rdy_o pulse is matched against the oldest outstanding expectation.
  always @(negedge clk_i) begin
    exp_t e;
    if (bus.rdy_o === 1'b1) begin
      n_rdy++;
      check("rdy_not_consecutive", {31'd0, prev_rdy}, 32'd0);
      check("busy_low_at_rdy", {31'd0, bus.busy_o}, 32'd0);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rdy: actual pulse with quot %h rem %h, required none", bus.quot_o, bus.rem_o);
      end else begin
        e = sb.pop_front();
        check("quot", bus.quot_o, e.q);
        check("rem", bus.rem_o, e.r);
        check("latency", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
    prev_rdy = bus.rdy_o;
  end

  task automatic issue(input logic [32:0] a, input logic [32:0] b, input bit hold = 1'b0);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk_i);
    while (bus.busy_o === 1'b1 && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    if (guard >= 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: actual busy after %0d cycles, required idle", guard);
    end
    bus.ai    = a;
    bus.bi    = b;
    bus.req_i = 1'b1;
    @(posedge clk_i);
    #1;
    model(a, b, e.q, e.r, e.lat);
    e.acc = cyc;
    sb.push_back(e);
    n_expect_rdy++;
    check("busy_after_accept", {31'd0, bus.busy_o}, 32'd1);
    // Operands are free to change once accepted.
    bus.ai = {1'($urandom), 32'($urandom)};
    bus.bi = {1'($urandom), 32'($urandom)};
    if (!hold) bus.req_i = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] x, y;
    bit          sx, sy;
    int          guard;

    rst_i     = 1'b1;
    bus.req_i = 1'b0;
    bus.ai    = '0;
    bus.bi    = '0;
    repeat (3) @(negedge clk_i);
    check("reset_quot", bus.quot_o, 32'd0);
    check("reset_rem", bus.rem_o, 32'd0);
    check("reset_rdy", {31'd0, bus.rdy_o}, 32'd0);
    check("reset_busy", {31'd0, bus.busy_o}, 32'd0);
    rst_i = 1'b0;

    // Directed corner cases
    issue(33'sd7, 33'sd2);
    issue(-33'sd7, 33'sd2);
    issue(33'sd7, -33'sd2);
    issue(33'h0_1234_5678, 33'd0);
    issue(33'h1_8000_0000, 33'h1_FFFF_FFFF);
    issue(33'h0_FFFF_FFFF, 33'd1);
    issue(33'sd5, 33'sd9);
    issue(-33'sd5, 33'sd9);
    issue(-33'sd9, 33'd0);
    issue(33'h0_8000_0000, 33'h0_0000_0002);
    wait_drain();

    // Randomized signed and unsigned operands
    for (int i = 0; i < 40; i++) begin
      x  = $urandom;
      y  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) y = 32'd0;
      sx = 1'($urandom_range(0, 1));
      sy = 1'($urandom_range(0, 1));
      issue(sx ? {x[31], x} : {1'b0, x}, sy ? {y[31], y} : {1'b0, y});
    end
    wait_drain();

    // Asynchronous reset ten cycles into a division aborts it with no rdy pulse
    issue(33'sd1000, 33'sd3);
    repeat (10) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check("midop_reset_quot", bus.quot_o, 32'd0);
    check("midop_reset_rem", bus.rem_o, 32'd0);
    check("midop_reset_rdy", {31'd0, bus.rdy_o}, 32'd0);
    check("midop_reset_busy", {31'd0, bus.busy_o}, 32'd0);
    sb.delete();
    n_expect_rdy--;
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (40) @(negedge clk_i);

    // Request held high throughout is not re-accepted while busy
    issue(33'sd100, 33'sd7, 1'b1);
    guard = 0;
    while (bus.rdy_o !== 1'b1 && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    bus.req_i = 1'b0;
    if (guard >= 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL held_req_timeout: actual no rdy after %0d cycles, required rdy", guard);
    end
    repeat (40) @(negedge clk_i);
    wait_drain();
    check("rdy_pulse_count", 32'(n_rdy), 32'(n_expect_rdy));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
